// File: rtl/md_pkg.sv
// Shared op-code values and FSM state encoding for the multiply/divide unit.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'b0000;
  localparam logic [3:0] MD_MULTU = 4'b0001;
  localparam logic [3:0] MD_DIV   = 4'b0010;
  localparam logic [3:0] MD_DIVU  = 4'b0011;
  localparam logic [3:0] MD_MTHI  = 4'b0100;
  localparam logic [3:0] MD_MTLO  = 4'b0101;
  localparam logic [3:0] MD_MADD  = 4'b0110;
  localparam logic [3:0] MD_MADDU = 4'b0111;
  localparam logic [3:0] MD_MSUB  = 4'b1000;
  localparam logic [3:0] MD_MSUBU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// then a one-cycle result phase where signs are re-applied to quotient/remainder.
module md_divider
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_abort,
  input  logic             i_freeze,
  output logic             o_busy,
  output logic             o_last,
  output logic             o_done,
  output logic             o_dz,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic             r_fix;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // The most-negative magnitude is still correct when read as unsigned.
  always_comb begin
    w_a_neg = i_signed & i_dividend[WIDTH-1];
    w_b_neg = i_signed & i_divisor[WIDTH-1];
    w_a_mag = w_a_neg ? -i_dividend : i_dividend;
    w_b_mag = w_b_neg ? -i_divisor : i_divisor;
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_div};
    w_ge    = ~w_diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_fix   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_fix  <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_fix   <= 1'b0;
      r_cnt   <= '0;
      r_quo   <= w_a_mag;
      r_rem   <= '0;
      r_div   <= w_b_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= (i_divisor == '0);
    end else if (!i_freeze) begin
      if (r_busy) begin
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_fix  <= 1'b1;
          r_cnt  <= '0;
        end
      end else begin
        r_fix <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy | r_fix;
  assign o_last = r_busy & ~i_freeze & ~i_abort & (r_cnt == CW'(WIDTH - 1));
  assign o_done = r_fix;
  assign o_dz   = r_dz;
  assign o_quo  = r_neg_q ? -r_quo : r_quo;
  assign o_rem  = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/md_unit_iter.sv
// EX-stage multiply/divide unit with HI/LO registers, cancel and completion pulse.
// Define MD_MADD_EN to build the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit_iter
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MD_ctr,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic             lock_muldiv,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HIO,
  output logic [WIDTH-1:0] LOO
);

  localparam int CW = $clog2(MUL_LAT + 1);

  md_state_e          r_state;
  md_state_e          w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_next;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_mul_fire;
  logic               w_div_fire;
  logic               w_mul_signed;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_result;

  logic               w_div_busy;
  logic               w_div_last;
  logic               w_div_done;
  logic               w_div_dz;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_div_rem;

  assign Busy     = (r_state != ST_IDLE);
  assign w_accept = Start & ~Busy & ~lock_muldiv & ~Cancel;

  always_comb begin
    w_is_mul = (MD_ctr == MD_MULT) || (MD_ctr == MD_MULTU);
`ifdef MD_MADD_EN
    if (MD_ctr inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU}) w_is_mul = 1'b1;
`endif
    w_is_div = (MD_ctr == MD_DIV) || (MD_ctr == MD_DIVU);
  end

  // Product is formed from the latched operands, so it is stable for the whole op.
  always_comb begin
    w_mul_signed = (r_op == MD_MULT) || (r_op == MD_MADD) || (r_op == MD_MSUB);
    w_ext_a = w_mul_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    w_ext_b = w_mul_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    w_prod  = w_ext_a * w_ext_b;
`ifdef MD_MADD_EN
    case (r_op)
      MD_MADD, MD_MADDU: w_mul_result = {r_hi, r_lo} + w_prod;
      MD_MSUB, MD_MSUBU: w_mul_result = {r_hi, r_lo} - w_prod;
      default:           w_mul_result = w_prod;
    endcase
`else
    w_mul_result = w_prod;
`endif
  end

  md_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_accept & w_is_div),
    .i_signed   (MD_ctr == MD_DIV),
    .i_dividend (RD1),
    .i_divisor  (RD2),
    .i_abort    (Cancel),
    .i_freeze   (lock_muldiv),
    .o_busy     (w_div_busy),
    .o_last     (w_div_last),
    .o_done     (w_div_done),
    .o_dz       (w_div_dz),
    .o_quo      (w_div_quo),
    .o_rem      (w_div_rem)
  );

  // Cancel overrides everything, including a completion on the same edge.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_mul_fire   = 1'b0;
    w_div_fire   = 1'b0;
    if (Cancel) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_mul) begin
            w_state_next = ST_MUL;
            w_cnt_next   = CW'(1);
          end else if (w_accept && w_is_div) begin
            w_state_next = ST_DIV;
          end
        end
        ST_MUL: begin
          if (!lock_muldiv) begin
            if (r_cnt == CW'(MUL_LAT)) begin
              w_state_next = ST_IDLE;
              w_cnt_next   = '0;
              w_mul_fire   = 1'b1;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
        end
        ST_DIV: begin
          if (!w_div_busy)     w_state_next = ST_IDLE;
          else if (w_div_last) w_state_next = ST_FIX;
        end
        ST_FIX: begin
          if (!lock_muldiv && w_div_done) begin
            w_state_next = ST_IDLE;
            w_div_fire   = 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_op <= MD_ctr;
        r_a  <= RD1;
        r_b  <= RD2;
      end
    end
  end

  // A divide by zero runs to completion and pulses Done but leaves HI/LO alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_mul_fire | w_div_fire;
      if (w_accept && (MD_ctr == MD_MTHI)) begin
        r_hi <= RD1;
      end else if (w_accept && (MD_ctr == MD_MTLO)) begin
        r_lo <= RD1;
      end else if (w_mul_fire) begin
        {r_hi, r_lo} <= w_mul_result;
      end else if (w_div_fire && !w_div_dz) begin
        r_hi <= w_div_rem;
        r_lo <= w_div_quo;
      end
    end
  end

  assign Done = r_done;
  assign HIO  = r_hi;
  assign LOO  = r_lo;

endmodule
